// File: rtl/rc5_key_schedule_ctrl_pkg.sv
// Shared definitions for the RC5 key-schedule controller.
// Word/table geometry, FSM state encoding, the RC5-32 magic constants and a
// word-rotate helper used by the mixing datapath.
package rc5_key_schedule_ctrl_pkg;

  localparam int unsigned W   = 32;  // word width (power of 2)
  localparam int unsigned T   = 26;  // S table entries (2*rounds+2)
  localparam int unsigned C   = 4;   // L words (key words)
  localparam int unsigned LGW = 5;   // log2(W), rotate-amount width
  localparam int unsigned AW  = 5;   // S read-address width

  localparam int unsigned MIX_ITERS = 3 * ((T > C) ? T : C);

  localparam int unsigned TW = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned KW = (MIX_ITERS > 1) ? $clog2(MIX_ITERS) : 1;

  localparam logic [W-1:0] P32 = 32'hB7E1_5163;
  localparam logic [W-1:0] Q32 = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MIX  = 2'd2
  } state_e;

  // Rotate left; the doubled word makes a shift of 0 return x unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [LGW-1:0] n);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*W-1:W];
  endfunction

endpackage

// File: rtl/rc5_key_schedule_ctrl_if.sv
// Bus between the key loader / cipher core and the key-schedule controller.
//   start, pW, qW, l_words : schedule request and its operands
//   busy, done, key_valid  : schedule status
//   s_addr / s_data        : registered S-table read port
// master = requester side, slave = the controller.
interface rc5_key_schedule_ctrl_if;
  import rc5_key_schedule_ctrl_pkg::*;

  logic           start;
  logic [W-1:0]   pW;
  logic [W-1:0]   qW;
  logic [C*W-1:0] l_words;
  logic           busy;
  logic           done;
  logic           key_valid;
  logic [AW-1:0]  s_addr;
  logic [W-1:0]   s_data;

  modport master (
    output start, pW, qW, l_words, s_addr,
    input  busy, done, key_valid, s_data
  );

  modport slave (
    input  start, pW, qW, l_words, s_addr,
    output busy, done, key_valid, s_data
  );

endinterface

// File: rtl/rc5_mix_step.sv
// One RC5 key-schedule mixing iteration (purely combinational).
//   s_i, l_j : current S[i] and L[j]
//   a, b     : running A and B
//   a_n      : rotl(S[i]+A+B, 3)
//   b_n      : rotl(L[j]+a_n+B, (a_n+B) mod W)
module rc5_mix_step
  import rc5_key_schedule_ctrl_pkg::*;
(
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] l_j,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a_n,
  output logic [W-1:0] b_n
);

  logic [W-1:0] anb;

  always_comb begin
    a_n = rotl(s_i + a + b, LGW'(3));
    anb = a_n + b;
    b_n = rotl(l_j + anb, anb[LGW-1:0]);
  end

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key-schedule controller.
// On an accepted start it latches the packed L words, fills S from P/Q
// (INIT, T-1 cycles) and then runs the 3*max(T,C) mixing loop (MIX). The
// finished table is exposed through a registered read port.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, aborts any schedule in progress
//   bus  : rc5_key_schedule_ctrl_if slave (start/pW/qW/l_words in,
//          busy/done/key_valid out, s_addr in, s_data out 1-cycle latency)
module rc5_key_schedule_ctrl
  import rc5_key_schedule_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  rc5_key_schedule_ctrl_if.slave   bus
);

  state_e          state_q, state_d;
  logic [TW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q [T];
  logic [W-1:0]    s_d [T];
  logic [W-1:0]    l_q [C];
  logic [W-1:0]    l_d [C];
  logic            done_q, done_d;
  logic            key_valid_q, key_valid_d;
  logic [W-1:0]    s_data_q, s_data_d;

  logic [W-1:0]    s_cur;
  logic [W-1:0]    s_prev;
  logic [W-1:0]    l_cur;
  logic [W-1:0]    a_n;
  logic [W-1:0]    b_n;

  always_comb begin
    s_cur  = s_q[i_q];
    s_prev = s_q[idx_q - TW'(1)];
    l_cur  = l_q[j_q];
  end

  rc5_mix_step u_mix (
    .s_i (s_cur),
    .l_j (l_cur),
    .a   (a_q),
    .b   (b_q),
    .a_n (a_n),
    .b_n (b_n)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    l_d         = l_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;

    // The read port samples the table as it stands before this edge, so it
    // sees in-progress values while a schedule runs and never stalls it.
    s_data_d = (bus.s_addr < AW'(T)) ? s_q[bus.s_addr] : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          for (int unsigned n = 0; n < C; n++) begin
            l_d[n] = bus.l_words[n*W +: W];
          end
          s_d[0]      = bus.pW;
          idx_d       = TW'(1);
          a_d         = '0;
          b_d         = '0;
          key_valid_d = 1'b0;
          state_d     = ST_INIT;
        end
      end

      ST_INIT: begin
        for (int unsigned n = 1; n < T; n++) begin
          if (idx_q == TW'(n)) s_d[n] = s_prev + bus.qW;
        end
        idx_d = idx_q + TW'(1);
        if (idx_q == TW'(T-1)) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_MIX;
        end
      end

      ST_MIX: begin
        for (int unsigned n = 0; n < T; n++) begin
          if (i_q == TW'(n)) s_d[n] = a_n;
        end
        for (int unsigned n = 0; n < C; n++) begin
          if (j_q == CW'(n)) l_d[n] = b_n;
        end
        a_d = a_n;
        b_d = b_n;
        i_d = (i_q == TW'(T-1)) ? '0 : i_q + TW'(1);
        j_d = (j_q == CW'(C-1)) ? '0 : j_q + CW'(1);
        k_d = k_q + KW'(1);
        if (k_q == KW'(MIX_ITERS-1)) begin
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '{default: '0};
      l_q         <= '{default: '0};
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      s_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      l_q         <= l_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      s_data_q    <= s_data_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;
  assign bus.s_data    = s_data_q;

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Self-checking bench for rc5_key_schedule_ctrl: reset behaviour, INIT fill
// and first mix step, done/busy timing, ignored starts, back-to-back starts,
// and full S-table comparison against a software RC5-32 key schedule.
module tb_rc5_key_schedule_ctrl;

  logic clk;
  logic rst;

  rc5_key_schedule_ctrl_if bus ();

  rc5_key_schedule_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotl_m(input logic [31:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference RC5 key schedule (w=32, t=26, c=4); pushes S[0..25].
  function automatic void push_model(input logic [127:0] key,
                                     input logic [31:0] pw, input logic [31:0] qw);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [31:0] a, b;
    int unsigned i, j;
    for (int k = 0; k < 4; k++) l[k] = key[k*32 +: 32];
    s[0] = pw;
    for (int n = 1; n < 26; n++) s[n] = s[n-1] + qw;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      a = rotl_m(s[i] + a + b, 3);
      s[i] = a;
      b = rotl_m(l[j] + a + b, int'((a + b) & 32'd31));
      l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int n = 0; n < 26; n++) exp_q.push_back(s[n]);
  endfunction

  // Called #1 after an edge with the DUT idle (or start already held for a
  // back-to-back accept). Returns right after done when chain is set, with
  // start left high so the next call's first edge is an immediate accept.
  task automatic run_sched(input logic [127:0] key, input bit pulse_mid,
                           input bit spot, input bit push, input bit chain);
    int lat;
    int dones;
    bus.l_words = key;
    bus.start   = 1'b1;
    if (push) push_model(key, bus.pW, bus.qW);
    wait_edge();  // accept edge E
    bus.start   = 1'b0;
    bus.l_words = ~key;
    check_eq("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    check_eq("kv_after_accept", {31'd0, bus.key_valid}, 32'd0);
    lat = 0;
    dones = 0;
    for (int n = 1; n <= 200; n++) begin
      wait_edge();
      bus.start = pulse_mid && (n == 10 || n == 60);
      if (spot) begin
        if (n == 25) bus.s_addr = 5'd1;
        if (n == 26) begin
          check_eq("init_s1", bus.s_data, 32'h5618CB1C);
          bus.s_addr = 5'd2;
        end
        if (n == 27) begin
          check_eq("init_s2", bus.s_data, 32'hF45044D5);
          bus.s_addr = 5'd0;
        end
        if (n == 28) check_eq("mix1_s0", bus.s_data, 32'hBF0A8B1D);
      end
      if (n == 102) check_eq("busy_last_mix", {31'd0, bus.busy}, 32'd1);
      if (bus.done) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          check_eq("kv_with_done", {31'd0, bus.key_valid}, 32'd1);
          if (chain) begin
            check_eq("latency", lat, 32'd103);
            bus.start = 1'b1;
            return;
          end
        end
      end
      if (lat != 0 && n >= lat + 2) break;
    end
    check_eq("latency", lat, 32'd103);
    check_eq("done_count", dones, 32'd1);
    check_eq("busy_after_done", {31'd0, bus.busy}, 32'd0);
    check_eq("kv_hold", {31'd0, bus.key_valid}, 32'd1);
  endtask

  task automatic read_table();
    logic [31:0] e;
    for (int a = 0; a < 26; a++) begin
      bus.s_addr = 5'(a);
      wait_edge();
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", bus.s_data, ~bus.s_data);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("s_tab[%0d]", a), bus.s_data, e);
      end
    end
    bus.s_addr = 5'd26;
    wait_edge();
    check_eq("s_addr_26", bus.s_data, 32'd0);
    bus.s_addr = 5'd31;
    wait_edge();
    check_eq("s_addr_31", bus.s_data, 32'd0);
  endtask

  initial begin
    logic [127:0] k;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pW      = 32'hB7E15163;
    bus.qW      = 32'h9E3779B9;
    bus.l_words = '0;
    bus.s_addr  = '0;
    repeat (3) wait_edge();
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_kv", {31'd0, bus.key_valid}, 32'd0);
    check_eq("rst_sdata", bus.s_data, 32'd0);

    // Reset in the middle of MIX
    bus.l_words = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1;
    wait_edge();
    bus.start = 1'b0;
    repeat (50) wait_edge();
    check_eq("busy_mid_mix", {31'd0, bus.busy}, 32'd1);
    bus.s_addr = 5'd3;
    rst = 1'b1;
    wait_edge();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_done", {31'd0, bus.done}, 32'd0);
    check_eq("abort_kv", {31'd0, bus.key_valid}, 32'd0);
    check_eq("abort_sdata", bus.s_data, 32'd0);
    wait_edge();
    check_eq("abort_table_cleared", bus.s_data, 32'd0);

    // Zero key with INIT/first-mix spot reads
    run_sched(128'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    read_table();

    // Random keys, with starts pulsed during INIT and MIX
    k = {$urandom, $urandom, $urandom, $urandom};
    run_sched(k, 1'b1, 1'b0, 1'b1, 1'b0);
    read_table();
    k = {$urandom, $urandom, $urandom, $urandom};
    run_sched(k, 1'b1, 1'b0, 1'b1, 1'b0);
    read_table();

    // Back-to-back: start held through done, second key checked
    k = {$urandom, $urandom, $urandom, $urandom};
    run_sched(k, 1'b0, 1'b0, 1'b0, 1'b1);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_sched(k, 1'b0, 1'b0, 1'b1, 1'b0);
    read_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
